uart_cfg: RTL
=============

Name: uart_cfg

Overview:
- Parametrised successor UART: configurable data width, parity mode, stop-bit count, oversampling ratio and baud divisor.
- Adds valid/ready handshakes on both directions, parity/framing/overrun reporting, a 2-flop input synchroniser and 3-sample majority voting on RX.
- Sits between the board serial pins and the system logic, as a drop-in replacement for the fixed-format 8N1/8N2 UART.

Parameters:
- CLK_DIVIDE, 27, system clocks per oversample tick (50 MHz / (115200 * 16)); must be >= 1.
- OVERSAMPLE, 16, oversample ticks per bit; even, >= 4.
- DATA_BITS, 8, data bits per frame; 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits sent per TX frame: 1 or 2. RX always checks only the first stop bit.

Ports:
- clk  in  1  master clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  serial input, asynchronous to clk.
- tx  out  1  serial output; idle high.
- tx_valid  in  1  tx_data is valid and requests a send.
- tx_ready  out  1  transmitter can accept a word this cycle.
- tx_data  in  DATA_BITS  word to send, LSB first.
- rx_valid  out  1  rx_data holds an unread word.
- rx_ready  in  1  consumer accepts rx_data.
- rx_data  out  DATA_BITS  received word.
- rx_parity_err  out  1  parity mismatch on the word in rx_data; valid while rx_valid is high.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_overrun  out  1  one-cycle pulse: a frame completed while rx_valid was high; the new word is dropped.
- is_receiving  out  1  RX FSM not in R_IDLE.
- is_transmitting  out  1  TX FSM not in T_IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - tx = 1, tx_ready = 1.
  - rx_valid = 0, rx_data = 0, rx_parity_err = 0, rx_frame_err = 0, rx_overrun = 0.
  - Both FSMs idle; synchroniser flops = 1.
  - An asserted reset mid-frame aborts immediately and tx goes high asynchronously.
- Tick generation:
  - RX and TX each have an independent divider counting CLK_DIVIDE clocks per tick. Counter width is clog2(CLK_DIVIDE+1).
  - The TX divider restarts on TX accept. The RX divider restarts on start-edge detect.
  - One bit = OVERSAMPLE ticks = OVERSAMPLE*CLK_DIVIDE clocks.
- RX synchroniser: rx passes through 2 flops; rx_s is the output. All RX decisions use rx_s.
- TX FSM (T_IDLE, T_START, T_DATA, T_PARITY, T_STOP):
  - Handshake: accept occurs when tx_valid && tx_ready. tx_ready = (state == T_IDLE).
  - On accept, tx_data is latched, tx drives 0 on the next clock, and the FSM enters T_START.
  - Each state lasts exactly one bit.
  - T_DATA sends DATA_BITS bits, LSB first.
  - T_PARITY is skipped when PARITY = 0. The parity bit is odd or even over the data bits.
  - T_STOP holds tx = 1 for STOP_BITS bits, then returns to T_IDLE. tx_ready rises on the first clock back in T_IDLE.
  - A back-to-back tx_valid produces no idle gap beyond the stop bits.
  - tx_data changes after accept do not affect the frame in flight.
- RX FSM (R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT_HIGH):
  - R_IDLE: rx_s low enters R_START.
  - R_START: at tick OVERSAMPLE/2, sample. If high, it is a glitch: return to R_IDLE with no error flag.
  - Bit sampling: each bit value is the majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within that bit, counted from the bit start.
  - Shifting: R_DATA shifts DATA_BITS bits in, LSB first. R_PARITY is present only when PARITY != 0.
  - R_STOP, stop sampled high: the frame is good. If rx_valid is 0, load rx_data, set rx_valid = 1 and set rx_parity_err to the parity check result. If rx_valid is 1, pulse rx_overrun and keep the old word. Then go to R_IDLE.
  - R_STOP, stop sampled low: pulse rx_frame_err, discard the word and go to R_WAIT_HIGH. R_WAIT_HIGH stays until rx_s is high, which covers a break condition, then goes to R_IDLE.
- RX output handshake:
  - rx_valid clears on the cycle after rx_valid && rx_ready.
  - If a load and a clear fall in the same cycle, the load wins: rx_valid stays 1 with the new data, and no overrun is flagged.
- Latency: the RX word appears 1 clock after the mid-stop sample, plus 2 synchroniser clocks relative to the pin.

Test Plan:
- Baseline TX, CLK_DIVIDE=4, OVERSAMPLE=16, 8N1: send 0xA5 -> tx is low for 64 clocks, then 1,0,1,0,0,1,0,1 at 64 clocks each, then high for 64 clocks. tx_ready is low for exactly 640 clocks.
- Even parity, 7 data bits, 2 stop bits: loopback tx to rx and send 0x5B -> parity bit = 1, frame = 11 bits. rx_valid shows 0x5B with rx_parity_err = 0. Forcing the parity bit to 0 at the pin gives rx_parity_err = 1.
- Glitch and framing: a 20-clock low pulse on rx -> no rx_valid and no error. A frame with stop = 0 -> rx_frame_err pulses 1 clock. Holding rx low for 2000 clocks -> FSM stays in R_WAIT_HIGH, then a normal frame of 0x3C is received correctly.
- Overrun: receive 0x11 while holding rx_ready = 0, then 0x22 -> rx_overrun pulses once and rx_data stays 0x11. Asserting rx_ready then clears rx_valid.
- Noise immunity: a 1-tick inverted spike at the centre of data bit 3 of 0xFF -> majority voting still yields rx_data = 0xFF.
- Reset mid-frame: drop rst_n in the middle of bit 4 of a TX frame -> tx = 1 and tx_ready = 1 immediately. After release, a new send of 0x81 completes correctly.

Source files
------------

// File: rtl/uart_cfg.sv
// uart_cfg: parametrised UART with valid/ready handshakes, configurable frame
// format, parity/framing/overrun reporting and majority-voted RX sampling.
module uart_cfg #(
  parameter int CLK_DIVIDE = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 is_receiving,
  output logic                 is_transmitting
);

  localparam int DIV_W = $clog2(CLK_DIVIDE + 1);
  localparam int TCK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIVIDE - 1);
  localparam logic [TCK_W-1:0] TCK_LAST  = TCK_W'(OVERSAMPLE - 1);
  localparam logic [TCK_W-1:0] TCK_V0    = TCK_W'(OVERSAMPLE / 2 - 2);
  localparam logic [TCK_W-1:0] TCK_V1    = TCK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCK_W-1:0] TCK_V2    = TCK_W'(OVERSAMPLE / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY != 0);

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;

  tx_state_t            tx_state, tx_state_nxt;
  logic [DIV_W-1:0]     tx_div;
  logic [TCK_W-1:0]     tx_tck;
  logic [BIT_W-1:0]     tx_bit;
  logic                 tx_stop_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_accept, tx_tick, tx_bit_end, tx_nxt;

  assign tx_ready        = (tx_state == T_IDLE);
  assign is_transmitting = ~tx_ready;
  assign tx_accept       = tx_valid & tx_ready;
  assign tx_tick         = (tx_div == DIV_LAST);
  assign tx_bit_end      = tx_tick & (tx_tck == TCK_LAST);

  always_comb begin
    tx_state_nxt = tx_state;
    tx_nxt       = tx;
    case (tx_state)
      T_IDLE: begin
        if (tx_valid) begin
          tx_state_nxt = T_START;
          tx_nxt       = 1'b0;
        end
      end
      T_START: begin
        if (tx_bit_end) begin
          tx_state_nxt = T_DATA;
          tx_nxt       = tx_shift[0];
        end
      end
      T_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit != BIT_LAST) begin
            tx_nxt = tx_shift[1];
          end else if (HAS_PARITY) begin
            tx_state_nxt = T_PARITY;
            tx_nxt       = tx_par;
          end else begin
            tx_state_nxt = T_STOP;
            tx_nxt       = 1'b1;
          end
        end
      end
      T_PARITY: begin
        if (tx_bit_end) begin
          tx_state_nxt = T_STOP;
          tx_nxt       = 1'b1;
        end
      end
      T_STOP: begin
        if (tx_bit_end && (tx_stop_cnt == STOP_LAST)) tx_state_nxt = T_IDLE;
      end
      default: begin
        tx_state_nxt = T_IDLE;
        tx_nxt       = 1'b1;
      end
    endcase
  end

  // tx is reset asynchronously so an aborted frame releases the line at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx       <= tx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_div      <= '0;
      tx_tck      <= '0;
      tx_bit      <= '0;
      tx_stop_cnt <= 1'b0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
    end else if (tx_accept) begin
      tx_div      <= '0;
      tx_tck      <= '0;
      tx_bit      <= '0;
      tx_stop_cnt <= 1'b0;
      tx_shift    <= tx_data;
      tx_par      <= par_of(tx_data);
    end else begin
      tx_div <= tx_tick ? '0 : tx_div + 1'b1;
      if (tx_tick) tx_tck <= (tx_tck == TCK_LAST) ? '0 : tx_tck + 1'b1;
      if (tx_bit_end && (tx_state == T_DATA)) begin
        tx_shift <= tx_shift >> 1;
        tx_bit   <= tx_bit + 1'b1;
      end
      if (tx_bit_end && (tx_state == T_STOP)) tx_stop_cnt <= tx_stop_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT_HIGH
  } rx_state_t;

  rx_state_t            rx_state, rx_state_nxt;
  logic                 rx_meta, rx_s;
  logic [DIV_W-1:0]     rx_div;
  logic [TCK_W-1:0]     rx_tck;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;
  logic [1:0]           rx_votes;
  logic                 rx_tick, rx_bit_end, rx_at_v0, rx_at_v1, rx_at_v2;
  logic                 rx_maj, rx_start_det, stop_good, stop_bad, rx_load;

  assign rx_tick      = (rx_div == DIV_LAST);
  assign rx_bit_end   = rx_tick & (rx_tck == TCK_LAST);
  assign rx_at_v0     = rx_tick & (rx_tck == TCK_V0);
  assign rx_at_v1     = rx_tick & (rx_tck == TCK_V1);
  assign rx_at_v2     = rx_tick & (rx_tck == TCK_V2);
  assign rx_maj       = maj3(rx_votes[0], rx_votes[1], rx_s);
  assign rx_start_det = (rx_state == R_IDLE) & ~rx_s;
  assign is_receiving = (rx_state != R_IDLE);
  assign rx_load      = stop_good & (~rx_valid | rx_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    stop_good    = 1'b0;
    stop_bad     = 1'b0;
    case (rx_state)
      R_IDLE:   if (!rx_s) rx_state_nxt = R_START;
      R_START: begin
        if (rx_at_v1 && rx_s) rx_state_nxt = R_IDLE;
        else if (rx_bit_end)  rx_state_nxt = R_DATA;
      end
      R_DATA: begin
        if (rx_bit_end && (rx_bit == BIT_LAST))
          rx_state_nxt = HAS_PARITY ? R_PARITY : R_STOP;
      end
      R_PARITY: if (rx_bit_end) rx_state_nxt = R_STOP;
      // The stop decision is taken at the last vote so a following start
      // edge is never missed.
      R_STOP: begin
        if (rx_at_v2) begin
          if (rx_maj) begin
            stop_good    = 1'b1;
            rx_state_nxt = R_IDLE;
          end else begin
            stop_bad     = 1'b1;
            rx_state_nxt = R_WAIT_HIGH;
          end
        end
      end
      R_WAIT_HIGH: if (rx_s) rx_state_nxt = R_IDLE;
      default:     rx_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= R_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_div     <= '0;
      rx_tck     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
      rx_votes   <= 2'b11;
    end else begin
      if (rx_start_det) begin
        rx_div <= '0;
        rx_tck <= '0;
        rx_bit <= '0;
      end else begin
        rx_div <= rx_tick ? '0 : rx_div + 1'b1;
        if (rx_tick) rx_tck <= (rx_tck == TCK_LAST) ? '0 : rx_tck + 1'b1;
        if (rx_bit_end && (rx_state == R_DATA)) rx_bit <= rx_bit + 1'b1;
      end
      if (rx_at_v0) rx_votes[0] <= rx_s;
      if (rx_at_v1) rx_votes[1] <= rx_s;
      if (rx_at_v2 && (rx_state == R_DATA))   rx_shift   <= {rx_maj, rx_shift[DATA_BITS-1:1]};
      if (rx_at_v2 && (rx_state == R_PARITY)) rx_par_bit <= rx_maj;
    end
  end

  // A load in the same cycle as a consumer read takes priority over the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_frame_err <= stop_bad;
      rx_overrun   <= stop_good & rx_valid & ~rx_ready;
      if (rx_load) begin
        rx_valid      <= 1'b1;
        rx_data       <= rx_shift;
        rx_parity_err <= HAS_PARITY && (par_of(rx_shift) != rx_par_bit);
      end else if (rx_valid && rx_ready) begin
        rx_valid      <= 1'b0;
        rx_parity_err <= 1'b0;
      end
    end
  end

endmodule
